// File: rtl/receptor_jogada_esp.sv
// 8N1 UART receiver plus ASCII move-frame parser ("e4\n", 'T') feeding circuito_CL.
// Emits single-cycle temJogada/fimT pulses one cycle after the mid-stop-bit sample.
module receptor_jogada_esp #(
   parameter int CLKS_POR_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [2:0] jogadaFileira,
   output logic [2:0] jogadaColuna,
   output logic       temJogada,
   output logic       fimT,
   output logic       db_erro,
   output logic [3:0] db_estado
);

   localparam int MEIO = CLKS_POR_BIT / 2;
   localparam int CW   = $clog2(CLKS_POR_BIT);

   typedef enum logic [1:0] {Ocioso = 2'd0, Inicio = 2'd1, Dados = 2'd2, Parada = 2'd3} tipoEstadoRx;
   typedef enum logic [1:0] {EsperaCol = 2'd0, EsperaLin = 2'd1, EsperaFim = 2'd2} tipoEstadoPar;

   logic          rxMeta, rxSync;
   tipoEstadoRx   estadoRx, estadoRxD;
   logic [CW-1:0] clkCnt, clkCntD;
   logic [2:0]    bitCnt, bitCntD;
   logic [7:0]    shiftReg, shiftD;
   logic          byteOk, erroQuadro;

   tipoEstadoPar  estadoPar, estadoParD;
   logic [2:0]    col, colD, lin, linD;
   logic [2:0]    filD, colOutD;
   logic          temD, fimD, erroD;
   logic [7:0]    offCol, offLin;
   logic          ehColuna, ehLinha;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rxMeta   <= 1'b1;
         rxSync   <= 1'b1;
         estadoRx <= Ocioso;
         clkCnt   <= '0;
         bitCnt   <= '0;
         shiftReg <= 8'hFF;
      end else begin
         rxMeta   <= rx;
         rxSync   <= rxMeta;
         estadoRx <= estadoRxD;
         clkCnt   <= clkCntD;
         bitCnt   <= bitCntD;
         shiftReg <= shiftD;
      end
   end

   always_comb begin
      estadoRxD  = estadoRx;
      clkCntD    = clkCnt;
      bitCntD    = bitCnt;
      shiftD     = shiftReg;
      byteOk     = 1'b0;
      erroQuadro = 1'b0;
      unique case (estadoRx)
         Ocioso: begin
            if (!rxSync) begin
               estadoRxD = Inicio;
               clkCntD   = '0;
               bitCntD   = '0;
            end
         end
         Inicio: begin
            if (clkCnt == CW'(MEIO - 1)) begin
               clkCntD   = '0;
               estadoRxD = rxSync ? Ocioso : Dados;
            end else begin
               clkCntD = clkCnt + 1'b1;
            end
         end
         Dados: begin
            if (clkCnt == CW'(CLKS_POR_BIT - 1)) begin
               clkCntD = '0;
               shiftD  = {rxSync, shiftReg[7:1]};
               bitCntD = bitCnt + 3'd1;
               if (bitCnt == 3'd7) estadoRxD = Parada;
            end else begin
               clkCntD = clkCnt + 1'b1;
            end
         end
         Parada: begin
            if (clkCnt == CW'(CLKS_POR_BIT - 1)) begin
               clkCntD   = '0;
               estadoRxD = Ocioso;
               byteOk    = rxSync;
               erroQuadro = !rxSync;
            end else begin
               clkCntD = clkCnt + 1'b1;
            end
         end
      endcase
   end

   // Offsets from 'a' and '1'; only the low 3 bits matter once range-checked.
   assign offCol   = shiftReg - 8'h61;
   assign offLin   = shiftReg - 8'h31;
   assign ehColuna = (shiftReg >= 8'h61) && (shiftReg <= 8'h68);
   assign ehLinha  = (shiftReg >= 8'h31) && (shiftReg <= 8'h38);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estadoPar     <= EsperaCol;
         col           <= '0;
         lin           <= '0;
         jogadaFileira <= '0;
         jogadaColuna  <= '0;
         temJogada     <= 1'b0;
         fimT          <= 1'b0;
         db_erro       <= 1'b0;
      end else begin
         estadoPar     <= estadoParD;
         col           <= colD;
         lin           <= linD;
         jogadaFileira <= filD;
         jogadaColuna  <= colOutD;
         temJogada     <= temD;
         fimT          <= fimD;
         db_erro       <= erroD;
      end
   end

   always_comb begin
      estadoParD = estadoPar;
      colD       = col;
      linD       = lin;
      filD       = jogadaFileira;
      colOutD    = jogadaColuna;
      temD       = 1'b0;
      fimD       = 1'b0;
      erroD      = db_erro;
      if (erroQuadro) begin
         erroD      = 1'b1;
         estadoParD = EsperaCol;
      end else if (byteOk) begin
         if (shiftReg == 8'h54) begin
            fimD       = 1'b1;
            estadoParD = EsperaCol;
         end else begin
            unique case (estadoPar)
               EsperaCol: begin
                  if (ehColuna) begin
                     colD       = offCol[2:0];
                     estadoParD = EsperaLin;
                  end else if (shiftReg != 8'h0A && shiftReg != 8'h0D) begin
                     erroD = 1'b1;
                  end
               end
               EsperaLin: begin
                  if (ehLinha) begin
                     linD       = offLin[2:0];
                     estadoParD = EsperaFim;
                  end else begin
                     erroD      = 1'b1;
                     estadoParD = EsperaCol;
                  end
               end
               EsperaFim: begin
                  if (shiftReg == 8'h0A) begin
                     colOutD    = col;
                     filD       = lin;
                     temD       = 1'b1;
                     erroD      = 1'b0;
                     estadoParD = EsperaCol;
                  end else if (shiftReg != 8'h0D) begin
                     erroD      = 1'b1;
                     estadoParD = EsperaCol;
                  end
               end
               default: estadoParD = EsperaCol;
            endcase
         end
      end
   end

   assign db_estado = {estadoRx, estadoPar};

endmodule

// File: tb/tb_receptor_jogada_esp.sv
// Scoreboard bench for receptor_jogada_esp: expected pulses queued at frame start,
// checked (value and exact cycle) when temJogada/fimT appear.
module tb_receptor_jogada_esp;

   localparam int CLKS = 4;
   // posedges from start-bit launch to the output pulse: 2 sync + 1 detect + half + 9 bits
   localparam int LAT  = 3 + CLKS / 2 + 9 * CLKS;

   typedef struct {
      bit fim;
      int col;
      int lin;
      int erro;
      int cyc;
   } evento_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic [2:0] jogadaFileira, jogadaColuna;
   logic       temJogada, fimT, db_erro;
   logic [3:0] db_estado;

   evento_t sb[$];
   int      cyc = 0;
   int      nChecks = 0;
   int      nPass = 0;

   receptor_jogada_esp #(.CLKS_POR_BIT(CLKS)) dut (
      .clock        (clock),
      .reset        (reset),
      .rx           (rx),
      .jogadaFileira(jogadaFileira),
      .jogadaColuna (jogadaColuna),
      .temJogada    (temJogada),
      .fimT         (fimT),
      .db_erro      (db_erro),
      .db_estado    (db_estado)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic verifica(input string tag, input int obs, input int esp);
      nChecks++;
      if (obs == esp) nPass++;
      else $display("FAIL %s: obtido=%0d esperado=%0d", tag, obs, esp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // tipo: 0 no pulse expected, 1 move (c,l), 2 fimT; erro is db_erro expected in the pulse cycle
   task automatic sendByte(input logic [7:0] b, input bit stopOk, input int tipo,
                           input int c, input int l, input int erro);
      evento_t ev;
      if (tipo != 0) begin
         ev.fim  = (tipo == 2);
         ev.col  = c;
         ev.lin  = l;
         ev.erro = erro;
         ev.cyc  = cyc + LAT;
         sb.push_back(ev);
      end
      rx = 1'b0;
      idle(CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(CLKS);
      end
      rx = stopOk;
      idle(CLKS);
   endtask

   task automatic tx(input logic [7:0] b);
      sendByte(b, 1'b1, 0, 0, 0, 0);
   endtask

   always @(negedge clock) begin
      evento_t ev;
      if (!reset && (temJogada || fimT)) begin
         verifica("pulsos_simultaneos", int'(temJogada & fimT), 0);
         if (sb.size() == 0) begin
            verifica("pulso_inesperado", int'(temJogada) + int'(fimT), 0);
         end else begin
            ev = sb.pop_front();
            verifica("tipo_pulso", int'(fimT), int'(ev.fim));
            verifica("latencia", cyc, ev.cyc);
            if (!ev.fim) begin
               verifica("jogadaColuna", int'(jogadaColuna), ev.col);
               verifica("jogadaFileira", int'(jogadaFileira), ev.lin);
            end
            verifica("db_erro_pulso", int'(db_erro), ev.erro);
         end
      end
   end

   initial begin
      #1;
      verifica("reset_fileira", int'(jogadaFileira), 0);
      verifica("reset_coluna", int'(jogadaColuna), 0);
      verifica("reset_pulsos", int'(temJogada) + int'(fimT), 0);
      verifica("reset_erro", int'(db_erro), 0);
      verifica("reset_estado", int'(db_estado), 0);
      idle(3);
      reset = 1'b0;
      idle(3);

      // 1: basic move
      tx("e"); tx("4");
      sendByte(8'h0A, 1'b1, 1, 4, 3, 0);
      idle(4);
      verifica("t1_erro", int'(db_erro), 0);

      // 2: CR tolerated, back-to-back frames, hold between pulses
      tx("a"); tx("1"); tx(8'h0D);
      sendByte(8'h0A, 1'b1, 1, 0, 0, 0);
      tx("h");
      verifica("t2_hold_col", int'(jogadaColuna), 0);
      verifica("t2_hold_lin", int'(jogadaFileira), 0);
      tx("8");
      sendByte(8'h0A, 1'b1, 1, 7, 7, 0);
      idle(4);

      // 3: timer token drops partial move
      tx("e");
      sendByte("T", 1'b1, 2, 0, 0, 0);
      tx("e"); tx("4");
      sendByte(8'h0A, 1'b1, 1, 4, 3, 0);
      idle(4);
      verifica("t3_erro", int'(db_erro), 0);

      // 4: bad bytes set sticky error; valid move clears it
      tx("z");
      idle(3);
      verifica("t4_erro_z", int'(db_erro), 1);
      tx("b"); tx("9"); tx(8'h0A);
      idle(3);
      verifica("t4_erro_sticky", int'(db_erro), 1);
      verifica("t4_hold_col", int'(jogadaColuna), 4);
      tx("c"); tx("2");
      sendByte(8'h0A, 1'b1, 1, 2, 1, 0);
      idle(4);
      verifica("t4_erro_limpo", int'(db_erro), 0);

      // 5: framing error
      sendByte("e", 1'b0, 0, 0, 0, 0);
      rx = 1'b1;
      idle(3 * CLKS);
      verifica("t5_erro_quadro", int'(db_erro), 1);
      verifica("t5_hold_col", int'(jogadaColuna), 2);
      verifica("t5_hold_lin", int'(jogadaFileira), 1);
      tx("d"); tx("5");
      sendByte(8'h0A, 1'b1, 1, 3, 4, 0);
      idle(4);

      // 6a: one-cycle glitch is a false start
      rx = 1'b0;
      idle(1);
      rx = 1'b1;
      idle(3 * CLKS);
      verifica("t6_glitch_estado", int'(db_estado[3:2]), 0);
      verifica("t6_glitch_erro", int'(db_erro), 0);

      // 6b: reset in the middle of the data bits
      rx = 1'b0;
      idle(3 * CLKS);
      verifica("t6_em_dados", int'(db_estado[3:2]), 2);
      reset = 1'b1;
      #1;
      verifica("t6_rst_col", int'(jogadaColuna), 0);
      verifica("t6_rst_lin", int'(jogadaFileira), 0);
      verifica("t6_rst_estado", int'(db_estado), 0);
      rx = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(12 * CLKS);
      tx("g"); tx("7");
      sendByte(8'h0A, 1'b1, 1, 6, 6, 0);
      idle(4 * CLKS);
      verifica("fila_vazia", sb.size(), 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
